// File: rtl/wrapper_ahb_packet_initiator.sv
// wrapper_ahb_packet_initiator
//
// AHB-Lite write initiator for the packet-constructor input window of an
// accelerator wrapper. A wide packet accepted on the valid/ready stream is
// written one 32-bit word per transfer, most-significant word first. Packet
// boundaries are encoded in the address: non-last packets rotate through
// slots 0..S-2, and a last packet always lands in slot S-1.
//
// Optional feature macro: WRAPPER_AHB_INIT_INCR_BURST_EN
//   defined   -> HBURSTM = INCR, first word NONSEQ, remaining words SEQ
//   undefined -> HBURSTM = SINGLE, every word NONSEQ
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HADDRM .. HWDATAM     AHB-Lite manager outputs (all registered)
//   HREADYM, HRESPM       AHB-Lite manager inputs
//   data_req              target can take a packet (sampled only when idle)
//   packet_data*          packet stream in (payload, last flag, valid/ready)
//   xfer_error            one-cycle pulse when a packet is dropped on error
module wrapper_ahb_packet_initiator #(
  parameter int          ADDRWIDTH   = 11,
  parameter int          PACKETWIDTH = 512,
  parameter logic [31:0] BASEADDR    = 32'h0000_0000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  output logic [31:0]            HADDRM,
  output logic [1:0]             HTRANSM,
  output logic [2:0]             HSIZEM,
  output logic [2:0]             HBURSTM,
  output logic                   HWRITEM,
  output logic [3:0]             HPROTM,
  output logic [31:0]            HWDATAM,
  input  logic                   HREADYM,
  input  logic                   HRESPM,
  input  logic                   data_req,
  input  logic [PACKETWIDTH-1:0] packet_data,
  input  logic                   packet_data_last,
  input  logic                   packet_data_valid,
  output logic                   packet_data_ready,
  output logic                   xfer_error
);

  localparam int W    = PACKETWIDTH / 32;
  localparam int PB   = PACKETWIDTH / 8;
  localparam int S    = (2 ** ADDRWIDTH) / PB;
  localparam int KW   = (W > 1) ? $clog2(W) : 1;
  localparam int SW   = $clog2(S);
  localparam int PBSH = $clog2(PB);

  localparam logic [KW-1:0] K_LAST    = KW'(W - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(S - 1);
  localparam logic [SW-1:0] SLOT_WRAP = SW'(S - 2);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
`ifdef WRAPPER_AHB_INIT_INCR_BURST_EN
  localparam logic [1:0] TR_NEXT   = 2'b11;
  localparam logic [2:0] BURST     = 3'b001;
`else
  localparam logic [1:0] TR_NEXT   = 2'b10;
  localparam logic [2:0] BURST     = 3'b000;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  state_t                 state_r;
  logic [PACKETWIDTH-1:0] pkt_r;
  logic [KW-1:0]          k_r;
  logic [SW-1:0]          sp_r;
  logic [SW-1:0]          slot_r;
  logic                   last_r;

  // Byte address of word k inside a given packet slot.
  function automatic logic [31:0] word_addr(input logic [SW-1:0] slot,
                                            input logic [KW-1:0] k);
    return BASEADDR + (32'(slot) << PBSH) + (32'(k) << 2);
  endfunction

  assign HSIZEM = 3'b010;
  assign HPROTM = 4'b0011;

  // Transfer sequencer: handshake, address/data pipeline, error recovery.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r           <= ST_IDLE;
      HADDRM            <= BASEADDR;
      HTRANSM           <= TR_IDLE;
      HBURSTM           <= 3'b000;
      HWRITEM           <= 1'b0;
      HWDATAM           <= 32'h0000_0000;
      packet_data_ready <= 1'b0;
      xfer_error        <= 1'b0;
      pkt_r             <= {PACKETWIDTH{1'b0}};
      k_r               <= {KW{1'b0}};
      sp_r              <= {SW{1'b0}};
      slot_r            <= {SW{1'b0}};
      last_r            <= 1'b0;
    end else begin
      xfer_error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (packet_data_valid && packet_data_ready) begin
            pkt_r             <= packet_data;
            last_r            <= packet_data_last;
            slot_r            <= packet_data_last ? SLOT_LAST : sp_r;
            k_r               <= {KW{1'b0}};
            HADDRM            <= word_addr(packet_data_last ? SLOT_LAST : sp_r, {KW{1'b0}});
            HTRANSM           <= TR_NONSEQ;
            HWRITEM           <= 1'b1;
            HBURSTM           <= BURST;
            packet_data_ready <= 1'b0;
            state_r           <= ST_ADDR;
          end else begin
            packet_data_ready <= data_req;
          end
        end
        ST_ADDR: begin
          if (HRESPM && !HREADYM) begin
            // First error cycle: cancel the pending address phase.
            HTRANSM <= TR_IDLE;
            HWRITEM <= 1'b0;
            state_r <= ST_ERR;
          end else if (HREADYM) begin
            // Word k accepted: its data phase starts, MS word shifts out first.
            HWDATAM <= pkt_r[PACKETWIDTH-1 -: 32];
            pkt_r   <= pkt_r << 32;
            if (k_r == K_LAST) begin
              HTRANSM <= TR_IDLE;
              HWRITEM <= 1'b0;
              state_r <= ST_DATA;
            end else begin
              k_r     <= k_r + KW'(1);
              HADDRM  <= word_addr(slot_r, k_r + KW'(1));
              HTRANSM <= TR_NEXT;
            end
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (HRESPM && !HREADYM) begin
            state_r <= ST_ERR;
          end else if (HREADYM) begin
            // Packet complete: only now does the slot pointer move.
            if (last_r) begin
              sp_r <= {SW{1'b0}};
            end else if (sp_r == SLOT_WRAP) begin
              sp_r <= {SW{1'b0}};
            end else begin
              sp_r <= sp_r + SW'(1);
            end
            packet_data_ready <= data_req;
            state_r           <= ST_IDLE;
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_ERR: begin
          if (HREADYM) begin
            xfer_error        <= 1'b1;
            packet_data_ready <= data_req;
            state_r           <= ST_IDLE;
          end else begin
            state_r <= ST_ERR;
          end
        end
        default: begin
          HTRANSM <= TR_IDLE;
          HWRITEM <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
